// File: rtl/chip8_pkg.sv
// Shared CHIP-8 definitions: requester indices, memory widths and the arbiter lock encoding.
package chip8_pkg;

    localparam int unsigned REQ_LOADER = 0;
    localparam int unsigned REQ_DRAW   = 1;
    localparam int unsigned REQ_CPU    = 2;

    localparam int unsigned MEM_ADDR_WIDTH = 12;
    localparam int unsigned MEM_DATA_WIDTH = 8;

    typedef enum logic {
        StIdle,
        StLocked
    } lock_state_e;

endpackage

// File: rtl/arb_age_ctr.sv
// Saturating wait counter for one requester; flags urgent once it has waited MAX_WAIT cycles.
module arb_age_ctr #(
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_i,
    input  logic gnt_i,
    output logic urgent_o
);

    localparam logic [7:0] MaxWait = 8'(MAX_WAIT);

    logic [7:0] age_q, age_d;

    always_comb begin
        age_d = 8'd0;
        if (req_i && !gnt_i) begin
            age_d = (age_q == 8'hFF) ? age_q : age_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age_q <= 8'd0;
        end else begin
            age_q <= age_d;
        end
    end

    assign urgent_o = (age_q >= MaxWait);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single memory port shared by loader, draw engine and CPU: locked > urgent > fixed priority,
// combinational grant, one-cycle registered read return.
module mem_port_arbiter
    import chip8_pkg::*;
#(
    parameter int unsigned N_REQ      = 3,
    parameter int unsigned ADDR_WIDTH = MEM_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = MEM_DATA_WIDTH,
    parameter int unsigned MAX_WAIT   = 8,
    parameter int unsigned LOCK_MAX   = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ-1:0]            we,
    input  logic [N_REQ-1:0]            lock,
    input  logic [N_REQ*ADDR_WIDTH-1:0] addr,
    input  logic [N_REQ*DATA_WIDTH-1:0] wdata,
    output logic [N_REQ-1:0]            gnt,
    output logic [N_REQ-1:0]            rvalid,
    output logic [DATA_WIDTH-1:0]       rdata,
    output logic [ADDR_WIDTH-1:0]       mem_raddr,
    output logic                        mem_we,
    output logic [ADDR_WIDTH-1:0]       mem_waddr,
    output logic [DATA_WIDTH-1:0]       mem_d,
    input  logic [DATA_WIDTH-1:0]       mem_q
);

    localparam int unsigned OwnerW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [7:0]  LockMax = 8'(LOCK_MAX);

    lock_state_e           state_q, state_d;
    logic [OwnerW-1:0]     owner_q, owner_d;
    logic [7:0]            lock_cnt_q, lock_cnt_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic [N_REQ-1:0]      rvalid_q;

    logic [N_REQ-1:0]      urgent, eligible, cand, gnt_c;
    logic [OwnerW-1:0]     gnt_idx;
    logic                  gnt_any, lock_hit, forced;

    for (genvar k = 0; k < N_REQ; k++) begin : g_age
        arb_age_ctr #(
            .MAX_WAIT (MAX_WAIT)
        ) u_age (
            .clk      (clk),
            .rst_n    (rst_n),
            .req_i    (req[k]),
            .gnt_i    (gnt_c[k]),
            .urgent_o (urgent[k])
        );
    end

    always_comb begin
        lock_hit = 1'b0;
        forced   = 1'b0;
        if (state_q == StLocked) begin
            if (lock_cnt_q < LockMax) begin
                lock_hit = req[owner_q] && lock[owner_q];
            end else begin
                forced = 1'b1;
            end
        end

        // A forced release benches the old owner for this one cycle only.
        eligible = req;
        if (forced) begin
            eligible[owner_q] = 1'b0;
        end
        cand = (|(eligible & urgent)) ? (eligible & urgent) : eligible;

        gnt_c   = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        if (rst_n) begin
            if (lock_hit) begin
                gnt_c[owner_q] = 1'b1;
                gnt_idx        = owner_q;
                gnt_any        = 1'b1;
            end else begin
                for (int k = N_REQ - 1; k >= 0; k--) begin
                    if (cand[k]) begin
                        gnt_c    = '0;
                        gnt_c[k] = 1'b1;
                        gnt_idx  = OwnerW'(k);
                        gnt_any  = 1'b1;
                    end
                end
            end
        end

        state_d    = StIdle;
        owner_d    = owner_q;
        lock_cnt_d = 8'd0;
        if (lock_hit) begin
            state_d    = StLocked;
            lock_cnt_d = lock_cnt_q + 8'd1;
        end else if (gnt_any && lock[gnt_idx]) begin
            state_d    = StLocked;
            owner_d    = gnt_idx;
            lock_cnt_d = 8'd1;
        end

        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_d     = '0;
        raddr_d   = raddr_q;
        if (gnt_any) begin
            if (we[gnt_idx]) begin
                mem_we    = 1'b1;
                mem_waddr = addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                mem_d     = wdata[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                raddr_d = addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
        mem_raddr = raddr_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            owner_q    <= '0;
            lock_cnt_q <= 8'd0;
            raddr_q    <= '0;
            rvalid_q   <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            lock_cnt_q <= lock_cnt_d;
            raddr_q    <= raddr_d;
            rvalid_q   <= gnt_c & ~we;
        end
    end

    assign gnt    = gnt_c;
    assign rvalid = rvalid_q;
    assign rdata  = mem_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a one-cycle-latency memory model behind the port.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 12;
    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [2:0]    req, we, lock, gnt, rvalid;
    logic [3*AW-1:0] addr;
    logic [3*DW-1:0] wdata;
    logic [DW-1:0] rdata, mem_d, mem_q;
    logic [AW-1:0] mem_raddr, mem_waddr;
    logic          mem_we;

    logic [DW-1:0] mem [0:4095];
    logic [2:0]    exp_starve [0:10];
    logic [2:0]    exp_lock   [0:6];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_d;
        mem_q <= mem[mem_raddr];
    end

    mem_port_arbiter #(
        .N_REQ      (3),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MAX_WAIT   (8),
        .LOCK_MAX   (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .we        (we),
        .lock      (lock),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .mem_raddr (mem_raddr),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_d     (mem_d),
        .mem_q     (mem_q)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem[12'h200] = 8'h6A;
        mem_q = 8'h00;
        for (int i = 0; i < 8; i++) exp_starve[i] = 3'b001;
        exp_starve[8]  = 3'b010;
        exp_starve[9]  = 3'b100;
        exp_starve[10] = 3'b001;
        for (int i = 0; i < 4; i++) exp_lock[i] = 3'b010;
        exp_lock[4] = 3'b100;
        exp_lock[5] = 3'b010;
        exp_lock[6] = 3'b010;

        // Reset held with every requester active
        rst_n = 1'b0;
        req   = 3'b111;
        we    = 3'b000;
        lock  = 3'b000;
        wdata = '0;
        addr  = {12'h300, 12'h100, 12'h050};
        #3;
        chk("rst_gnt", gnt, 3'b000);
        chk("rst_rvalid", rvalid, 3'b000);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_raddr", mem_raddr, 12'h000);
        chk("rst_waddr", mem_waddr, 12'h000);
        tick();
        rst_n = 1'b1;
        #2;
        chk("rel_gnt", gnt, 3'b001);
        chk("rel_raddr", mem_raddr, 12'h050);
        tick();
        req = 3'b000;
        #2;
        chk("rel_rvalid", rvalid, 3'b001);
        chk("idle_gnt", gnt, 3'b000);
        chk("idle_mem_we", mem_we, 1'b0);
        chk("idle_raddr_hold", mem_raddr, 12'h050);

        // CPU read with one-cycle return
        tick();
        req = 3'b100;
        addr[2*AW +: AW] = 12'h200;
        #2;
        chk("rd_gnt", gnt, 3'b100);
        chk("rd_raddr", mem_raddr, 12'h200);
        tick();
        req = 3'b000;
        #2;
        chk("rd_rvalid", rvalid, 3'b100);
        chk("rd_rdata", rdata, 8'h6A);

        // Loader write followed by CPU read of the same address
        tick();
        req = 3'b001;
        we  = 3'b001;
        addr[0 +: AW] = 12'h201;
        wdata[0 +: DW] = 8'hA2;
        #2;
        chk("wr_gnt", gnt, 3'b001);
        chk("wr_mem_we", mem_we, 1'b1);
        chk("wr_waddr", mem_waddr, 12'h201);
        chk("wr_d", mem_d, 8'hA2);
        tick();
        req = 3'b100;
        we  = 3'b000;
        addr[2*AW +: AW] = 12'h201;
        #2;
        chk("wr_no_rvalid", rvalid, 3'b000);
        chk("wr_rd_gnt", gnt, 3'b100);
        chk("wr_rd_mem_we", mem_we, 1'b0);
        tick();
        req = 3'b000;
        #2;
        chk("wr_rd_rvalid", rvalid, 3'b100);
        chk("wr_rd_rdata", rdata, 8'hA2);

        // Starvation: draw and CPU age together; draw wins the tie, CPU follows
        tick();
        req = 3'b111;
        for (int i = 0; i < 11; i++) begin
            #2;
            chk($sformatf("starve_%0d", i), gnt, exp_starve[i]);
            tick();
        end
        req = 3'b000;
        tick();

        // Draw lock against CPU with LOCK_MAX = 4
        req  = 3'b110;
        lock = 3'b010;
        for (int i = 0; i < 7; i++) begin
            #2;
            chk($sformatf("lock_%0d", i), gnt, exp_lock[i]);
            tick();
        end

        // Reset in the cycle after a draw read grant
        rst_n = 1'b0;
        #2;
        chk("mrst_rvalid", rvalid, 3'b000);
        chk("mrst_gnt", gnt, 3'b000);
        tick();
        rst_n = 1'b1;
        req   = 3'b011;
        lock  = 3'b010;
        #2;
        chk("mrst_rel_rvalid", rvalid, 3'b000);
        chk("mrst_idle_gnt", gnt, 3'b001);
        tick();
        req  = 3'b000;
        lock = 3'b000;
        #2;
        chk("mrst_next_rvalid", rvalid, 3'b001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
